reg_bank_writer: RTL and testbench
==================================

REG_BANK_WRITER -- requirements
Module: reg_bank_writer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of every register, of wr_data and of R0..R7.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 wr_valid  input  1  SHALL mark that a write request is present.
REQ-005 wr_ready  output  1  SHALL mark that the block accepts a request this cycle.
REQ-006 wr_adres  input  3  SHALL select the target register R0..R7.
REQ-007 wr_data  input  DATA_W  SHALL give the operand for LOAD.
REQ-008 wr_op  input  2  SHALL select the operation: 00 LOAD, 01 INC, 10 DEC, 11 CLR.
REQ-009 wr_protect  input  8  SHALL be the write-protect mask; bit n set protects Rn.
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 err  output  1  SHALL be a one-cycle pulse, coincident with done, flagging a rejected write.
REQ-012 flag_c  output  1  SHALL hold the wrap flag of the last completed INC/DEC.
REQ-013 R0..R7  output  DATA_W each  SHALL present the registered contents, intended to feed the 8:1 read mux.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-015 wr_ready SHALL be 1 only in IDLE.
REQ-016 Handshake: a request SHALL be accepted when wr_valid=1 and wr_ready=1 at a rising edge; wr_op, wr_adres, wr_data and wr_protect[wr_adres] SHALL be captured into holding registers at that edge.
REQ-017 On acceptance, IDLE SHALL go to EXEC; with wr_valid=0, IDLE SHALL remain IDLE.
REQ-018 EXEC SHALL last exactly one cycle and compute the result from the captured operands and the current Rn; at the closing edge it SHALL write Rn and go to DONE.
REQ-019 Results: LOAD gives wr_data; INC gives Rn+1 mod 2^DATA_W; DEC gives Rn-1 mod 2^DATA_W; CLR gives 0.
REQ-020 flag_c SHALL be set to 1 when INC wraps from all-ones to 0 or DEC wraps from 0 to all-ones, and set to 0 on any other INC/DEC.
REQ-021 flag_c SHALL be unchanged by LOAD, by CLR and by rejected requests.
REQ-022 If the captured protect bit is 1, Rn and flag_c SHALL be left unchanged, and err SHALL be 1 during DONE.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE unconditionally.
REQ-024 Latency: for a request accepted at edge k, Rn SHALL update at edge k+1, done SHALL be high between edges k+1 and k+2, and wr_ready SHALL return at edge k+2.
REQ-025 Maximum throughput SHALL be one request per 3 cycles.
REQ-026 wr_valid asserted during EXEC or DONE SHALL be ignored, with no capture.
REQ-027 wr_protect changes after acceptance SHALL NOT affect the in-flight request.
REQ-028 Registers not addressed SHALL hold their value on every cycle.
REQ-029 R0..R7, flag_c, done and err SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-030 While rst_n=0: R0..R7=0, flag_c=0, done=0, err=0, FSM=IDLE and wr_ready=1, applied asynchronously.
REQ-031 A reset asserted in EXEC or DONE SHALL discard the in-flight request; no write and no done pulse SHALL follow deassertion.
REQ-032 After rst_n rises, the first request SHALL be accepted at the first rising edge with wr_valid=1.

Verification
REQ-033 LOAD R3=0xA5, protect=0 -> at edge k+1 R3=0xA5; done=1 for one cycle; err=0; all other registers 0.
REQ-034 R5=0xFF then INC R5 -> R5=0x00, flag_c=1; a following DEC R5 -> R5=0xFF, flag_c=1; INC R5 from 0x10 -> 0x11, flag_c=0.
REQ-035 wr_protect=0x04, LOAD R2=0x55 -> R2 unchanged; done=1 and err=1 in the same cycle; flag_c unchanged.
REQ-036 wr_valid held high continuously with 4 back-to-back LOADs -> exactly one acceptance every 3 cycles; wr_ready=0 in EXEC and DONE; 4 done pulses.
REQ-037 rst_n pulsed low during EXEC of LOAD R7=0x3C -> R7=0, no done pulse, wr_ready=1 immediately after reset.
REQ-038 CLR R1 after R1=0x7E -> R1=0x00 and flag_c holds its previous value.

Source files
------------

// File: rtl/reg_bank_writer_if.sv
// Write-request bus of the register bank writer: valid/ready request
// channel plus the done/err completion pulses returned by the bank.
interface reg_bank_writer_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_adres;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_op;
  logic [7:0]        wr_protect;
  logic              done;
  logic              err;

  modport master (
    output wr_valid, wr_adres, wr_data, wr_op, wr_protect,
    input  wr_ready, done, err
  );

  modport slave (
    input  wr_valid, wr_adres, wr_data, wr_op, wr_protect,
    output wr_ready, done, err
  );
endinterface

// File: rtl/reg_bank_writer.sv
// Eight-register bank updated by LOAD/INC/DEC/CLR requests through a
// three-state IDLE/EXEC/DONE sequencer with per-register write protection.
module reg_bank_writer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_bank_writer_if.slave  bus,
  output logic              flag_c,
  output logic [DATA_W-1:0] R0,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R5,
  output logic [DATA_W-1:0] R6,
  output logic [DATA_W-1:0] R7
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [DATA_W-1:0] ONE_C   = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_C  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES_C  = {DATA_W{1'b1}};

  // Returns {wrap, value}; wrap is only meaningful for INC and DEC.
  function automatic logic [DATA_W:0] op_result(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = {1'b0, ZERO_C};
    case (op)
      OP_LOAD: res = {1'b0, data};
      OP_INC:  res = {(cur == ONES_C), cur + ONE_C};
      OP_DEC:  res = {(cur == ZERO_C), cur - ONE_C};
      OP_CLR:  res = {1'b0, ZERO_C};
      default: res = {1'b0, ZERO_C};
    endcase
    return res;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                ready_r;
  logic                done_r;
  logic                err_r;
  logic                flag_c_r;
  logic [1:0]          op_r;
  logic [2:0]          adr_r;
  logic [DATA_W-1:0]   data_r;
  logic                prot_r;
  logic [DATA_W-1:0]   regs_r [8];
  logic                accept_s;
  logic [DATA_W:0]     result_s;

  assign accept_s = bus.wr_valid && ready_r;
  assign result_s = op_result(op_r, regs_r[adr_r], data_r);

  // Next-state logic of the request sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, holding registers, register file and flop-driven status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      flag_c_r <= 1'b0;
      op_r     <= 2'b00;
      adr_r    <= 3'b000;
      data_r   <= ZERO_C;
      prot_r   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= ZERO_C;
      end
    end else begin
      state_r <= state_nxt_s;
      // ready tracks the upcoming state so it is IDLE-exact yet still a flop.
      ready_r <= (state_nxt_s == ST_IDLE);
      done_r  <= (state_r == ST_EXEC);
      err_r   <= (state_r == ST_EXEC) && prot_r;
      if (accept_s) begin
        op_r   <= bus.wr_op;
        adr_r  <= bus.wr_adres;
        data_r <= bus.wr_data;
        prot_r <= bus.wr_protect[bus.wr_adres];
      end
      if ((state_r == ST_EXEC) && !prot_r) begin
        regs_r[adr_r] <= result_s[DATA_W-1:0];
        if ((op_r == OP_INC) || (op_r == OP_DEC)) begin
          flag_c_r <= result_s[DATA_W];
        end
      end
    end
  end

  assign bus.wr_ready = ready_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign flag_c       = flag_c_r;
  assign R0 = regs_r[0];
  assign R1 = regs_r[1];
  assign R2 = regs_r[2];
  assign R3 = regs_r[3];
  assign R4 = regs_r[4];
  assign R5 = regs_r[5];
  assign R6 = regs_r[6];
  assign R7 = regs_r[7];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: directed scenarios plus random
// requests compared against an arithmetic model of the register bank.
module tb_reg_bank_writer;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_writer_if #(.DATA_W(DATA_W)) bus ();

  logic       flag_c;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0] rr [8];
  assign rr[0] = r0; assign rr[1] = r1; assign rr[2] = r2; assign rr[3] = r3;
  assign rr[4] = r4; assign rr[5] = r5; assign rr[6] = r6; assign rr[7] = r7;

  reg_bank_writer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flag_c(flag_c),
    .R0(r0), .R1(r1), .R2(r2), .R3(r3), .R4(r4), .R5(r5), .R6(r6), .R7(r7)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: register values as plain integers, wrap flag as a bit.
  int model_regs [8];
  bit model_flag;

  logic obs_timeout, obs_ready_exec, obs_done_exec, obs_done, obs_err;
  logic obs_ready_done, obs_done_after, obs_ready_after;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_flag = 1'b0;
  endfunction

  function automatic void model_apply(input int op, input int adr, input int data, input bit prot);
    if (prot) return;
    case (op)
      0: model_regs[adr] = data;
      1: begin model_flag = (model_regs[adr] == 255); model_regs[adr] = (model_regs[adr] + 1) % 256; end
      2: begin model_flag = (model_regs[adr] == 0); model_regs[adr] = (model_regs[adr] + 255) % 256; end
      default: model_regs[adr] = 0;
    endcase
  endfunction

  // Issues one request from a falling edge with the DUT idle and records
  // what the bus showed during EXEC, DONE and the cycle after.
  task automatic issue(input int op, input int adr, input int data, input int prot);
    int waited = 0;
    obs_timeout = 1'b0;
    while (bus.wr_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 10) begin
      obs_timeout = 1'b1;
      return;
    end
    bus.wr_valid = 1'b1;
    bus.wr_op = 2'(op);
    bus.wr_adres = 3'(adr);
    bus.wr_data = 8'(data);
    bus.wr_protect = 8'(prot);
    @(negedge clk);
    obs_ready_exec = bus.wr_ready;
    obs_done_exec = bus.done;
    // junk with valid high while busy: must be neither captured nor used
    bus.wr_op = 2'($urandom);
    bus.wr_adres = 3'($urandom);
    bus.wr_data = 8'($urandom);
    bus.wr_protect = 8'($urandom);
    @(negedge clk);
    obs_done = bus.done;
    obs_err = bus.err;
    obs_ready_done = bus.wr_ready;
    bus.wr_valid = 1'b0;
    model_apply(op, adr, data, ((prot >> adr) & 1) != 0);
    @(negedge clk);
    obs_done_after = bus.done;
    obs_ready_after = bus.wr_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.wr_ready); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL reset_done_err: got %b%b expected 00", bus.done, bus.err); end
    checks++; if (flag_c !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b expected 0", flag_c); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rr[i] !== 8'h00) begin failures++; $display("FAIL reset_R%0d: got %h expected 00", i, rr[i]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_r3();
    issue(0, 3, 8'hA5, 0);
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL load_timeout: got %b expected 0", obs_timeout); end
    checks++; if (obs_ready_exec !== 1'b0 || obs_done_exec !== 1'b0) begin failures++; $display("FAIL load_exec: got ready=%b done=%b expected 0 0", obs_ready_exec, obs_done_exec); end
    checks++; if (obs_done !== 1'b1 || obs_err !== 1'b0 || obs_ready_done !== 1'b0) begin failures++; $display("FAIL load_done: got done=%b err=%b ready=%b expected 1 0 0", obs_done, obs_err, obs_ready_done); end
    checks++; if (obs_done_after !== 1'b0 || obs_ready_after !== 1'b1) begin failures++; $display("FAIL load_after: got done=%b ready=%b expected 0 1", obs_done_after, obs_ready_after); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rr[i] !== 8'(model_regs[i])) begin failures++; $display("FAIL load_R%0d: got %h expected %h", i, rr[i], 8'(model_regs[i])); end
    end
  endtask

  task automatic test_wrap();
    int ops [5] = '{0, 1, 2, 0, 1};
    int dat [5] = '{255, 0, 0, 16, 0};
    int exp_r [5] = '{255, 0, 255, 16, 17};
    for (int s = 0; s < 5; s++) begin
      issue(ops[s], 5, dat[s], 0);
      checks++; if (r5 !== 8'(exp_r[s]) || r5 !== 8'(model_regs[5])) begin failures++; $display("FAIL wrap_R5_step%0d: got %h expected %h", s, r5, 8'(exp_r[s])); end
      checks++; if (flag_c !== model_flag) begin failures++; $display("FAIL wrap_flag_step%0d: got %b expected %b", s, flag_c, model_flag); end
      checks++; if (obs_done !== 1'b1 || obs_err !== 1'b0) begin failures++; $display("FAIL wrap_done_step%0d: got done=%b err=%b expected 1 0", s, obs_done, obs_err); end
    end
  endtask

  task automatic test_protect();
    issue(0, 6, 255, 0);
    issue(1, 6, 0, 0);
    issue(0, 2, 8'h55, 8'h04);
    checks++; if (r2 !== 8'(model_regs[2])) begin failures++; $display("FAIL protect_R2: got %h expected %h", r2, 8'(model_regs[2])); end
    checks++; if (obs_done !== 1'b1 || obs_err !== 1'b1) begin failures++; $display("FAIL protect_done_err: got done=%b err=%b expected 1 1", obs_done, obs_err); end
    checks++; if (flag_c !== 1'b1) begin failures++; $display("FAIL protect_flag: got %b expected 1", flag_c); end
    checks++; if (obs_done_after !== 1'b0) begin failures++; $display("FAIL protect_err_len: got done=%b expected 0", obs_done_after); end
    issue(0, 2, 8'h55, 8'hFB);
    checks++; if (r2 !== 8'h55 || obs_err !== 1'b0) begin failures++; $display("FAIL protect_other_bits: got R2=%h err=%b expected 55 0", r2, obs_err); end
  endtask

  task automatic test_clr();
    issue(0, 1, 8'h7E, 0);
    issue(0, 0, 255, 0);
    issue(1, 0, 0, 0);
    issue(3, 1, 8'h99, 0);
    checks++; if (r1 !== 8'h00) begin failures++; $display("FAIL clr_R1: got %h expected 00", r1); end
    checks++; if (flag_c !== 1'b1 || model_flag !== 1'b1) begin failures++; $display("FAIL clr_flag: got %b expected 1", flag_c); end
  endtask

  task automatic test_back_to_back();
    int adrs [4];
    int dones = 0;
    for (int c = 0; c < 12; c++) begin
      checks++; if (bus.wr_ready !== ((c % 3) == 0)) begin failures++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, bus.wr_ready, ((c % 3) == 0)); end
      checks++; if (bus.done !== ((c % 3) == 2)) begin failures++; $display("FAIL b2b_done_c%0d: got %b expected %b", c, bus.done, ((c % 3) == 2)); end
      if (bus.done === 1'b1) dones++;
      if ((c % 3) == 2) begin
        checks++; if (rr[adrs[c / 3]] !== 8'(model_regs[adrs[c / 3]])) begin failures++; $display("FAIL b2b_reg_req%0d: got %h expected %h", c / 3, rr[adrs[c / 3]], 8'(model_regs[adrs[c / 3]])); end
      end
      if ((c % 3) == 0) begin
        adrs[c / 3] = $urandom_range(0, 7);
        bus.wr_valid = 1'b1;
        bus.wr_op = 2'b00;
        bus.wr_adres = 3'(adrs[c / 3]);
        bus.wr_data = 8'($urandom);
        bus.wr_protect = 8'h00;
        model_apply(0, adrs[c / 3], int'(bus.wr_data), 1'b0);
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    checks++; if (dones != 4) begin failures++; $display("FAIL b2b_done_count: got %0d expected 4", dones); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_exec();
    bus.wr_valid = 1'b1;
    bus.wr_op = 2'b00;
    bus.wr_adres = 3'd7;
    bus.wr_data = 8'h3C;
    bus.wr_protect = 8'h00;
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (r7 !== 8'h00 || bus.wr_ready !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL rst_exec_async: got R7=%h ready=%b done=%b expected 00 1 0", r7, bus.wr_ready, bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || r7 !== 8'h00) begin failures++; $display("FAIL rst_exec_c%0d: got done=%b R7=%h expected 0 00", c, bus.done, r7); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rr[i] !== 8'h00) begin failures++; $display("FAIL rst_exec_R%0d: got %h expected 00", i, rr[i]); end
    end
    issue(0, 7, 8'h3C, 0);
    checks++; if (obs_ready_exec !== 1'b0 || r7 !== 8'h3C || obs_done !== 1'b1) begin failures++; $display("FAIL rst_first_req: got ready=%b R7=%h done=%b expected 0 3c 1", obs_ready_exec, r7, obs_done); end
  endtask

  task automatic test_random();
    int op, adr, data, prot;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 3);
      adr = $urandom_range(0, 7);
      data = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 0) : $urandom_range(0, 255);
      prot = $urandom_range(0, 255) & $urandom_range(0, 255);
      issue(op, adr, data, prot);
      checks++; if (obs_timeout !== 1'b0 || obs_done !== 1'b1 || obs_done_after !== 1'b0 || obs_ready_after !== 1'b1) begin failures++; $display("FAIL rand_hs_%0d: got to=%b done=%b after=%b ready=%b expected 0 1 0 1", n, obs_timeout, obs_done, obs_done_after, obs_ready_after); end
      checks++; if (obs_err !== (((prot >> adr) & 1) != 0)) begin failures++; $display("FAIL rand_err_%0d: got %b expected %b", n, obs_err, (((prot >> adr) & 1) != 0)); end
      checks++; if (flag_c !== model_flag) begin failures++; $display("FAIL rand_flag_%0d: got %b expected %b", n, flag_c, model_flag); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (rr[i] !== 8'(model_regs[i])) begin failures++; $display("FAIL rand_R%0d_%0d: got %h expected %h", i, n, rr[i], 8'(model_regs[i])); end
      end
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_op = 2'b00;
    bus.wr_adres = 3'd0;
    bus.wr_data = 8'h00;
    bus.wr_protect = 8'h00;
    model_reset();
    test_reset();
    test_load_r3();
    test_wrap();
    test_protect();
    test_clr();
    test_back_to_back();
    test_reset_in_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
